// File: rtl/hazard_ctrl_param.sv
// Hazard and stall controller for the 5-stage pipeline with a data cache.
// Produces E-stage forwarding selects, load-use stalls, branch flushes and a
// cache-miss freeze. The freeze is sequenced by a two-state FSM with a down-counter.
// Optional feature macro: HAZ_PERF_CNT_EN adds three saturating perf counters
// (perf_stall, perf_miss, perf_flush). When the macro is undefined, those counters,
// their ports and the PERF_W parameter are absent.
module hazard_ctrl_param #(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned MISS_PENALTY = 5,
    parameter int unsigned CNT_W        = 8
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int unsigned PERF_W       = 32
`endif
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              hit,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic              MemtoRegE,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              PCSrcE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_miss,
    output logic [PERF_W-1:0] perf_flush
`endif
);

    typedef enum logic {
        StRun,
        StMiss
    } state_e;

    // A penalty of 1 means the detection cycle alone covers the miss.
    localparam bit              MultiCycle = (MISS_PENALTY > 1);
    localparam logic [CNT_W-1:0] MissLoad  = CNT_W'(MISS_PENALTY - 1);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic miss_now;
    logic freeze;
    logic branch;
    logic lwstall;

    // Selects the forwarding source for one E-stage operand; M is newer than W.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              wr_m,
        input logic [REG_AW-1:0] dst_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] dst_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (wr_m && (src == dst_m)) begin
                sel = 2'b10;
            end else if (wr_w && (src == dst_w)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    // Forwarding selects, forced to the register file while reset is held.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (CLR) begin
            ForwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
            ForwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
        end
    end

    // Hazard conditions; a miss is only detected in RUN so hit is ignored during MISS.
    always_comb begin
        miss_now = (MemtoRegM | MemWriteM) & ~hit & (state_q == StRun);
        freeze   = miss_now | (state_q == StMiss);
        branch   = PCSrcE & ~freeze;
        // For a load in E the destination register is RtE.
        lwstall  = MemtoRegE & ((RsD == RtE) | (RtD == RtE)) & (RtE != '0);
    end

    // Stall/flush decode with priority freeze > branch > load-use; all quiet in reset.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (CLR) begin
            if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (branch) begin
                // The D instruction dies, so any load-use stall on it is moot.
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lwstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // Miss-penalty FSM: the detection cycle plus MISS_PENALTY-1 cycles in MISS.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (miss_now && MultiCycle) begin
                        state_q <= StMiss;
                        cnt_q   <= MissLoad;
                    end
                end
                StMiss: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntOne) begin
                        state_q <= StRun;
                    end
                end
                default: begin
                    state_q <= StRun;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    localparam logic [PERF_W-1:0] PerfMax = '1;

    // Saturating event counters; they stick at all-ones rather than wrapping.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            perf_stall <= '0;
            perf_miss  <= '0;
            perf_flush <= '0;
        end else begin
            if (StallF && (perf_stall != PerfMax)) begin
                perf_stall <= perf_stall + 1'b1;
            end
            if (miss_now && (perf_miss != PerfMax)) begin
                perf_miss <= perf_miss + 1'b1;
            end
            if (FlushD && (perf_flush != PerfMax)) begin
                perf_flush <= perf_flush + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Directed bench for hazard_ctrl_param: one instance with the default miss penalty (5)
// and one with a penalty of 1, sharing stimulus.
module tb_hazard_ctrl_param;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       hit;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegM, WriteRegW;
    logic       MemtoRegE, MemtoRegM, MemWriteM, RegWriteM, RegWriteW, PCSrcE;

    logic       a_stall_f, a_stall_d, a_stall_e, a_stall_m, a_flush_d, a_flush_e, a_flush_w;
    logic [1:0] a_fwd_a, a_fwd_b;
    logic       b_stall_f, b_stall_d, b_stall_e, b_stall_m, b_flush_d, b_flush_e, b_flush_w;
    logic [1:0] b_fwd_a, b_fwd_b;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] a_perf_stall, a_perf_miss, a_perf_flush;
    logic [31:0] b_perf_stall, b_perf_miss, b_perf_flush;
`endif

    // Packed as {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}.
    logic [6:0] a_vec, b_vec;
    assign a_vec = {a_stall_f, a_stall_d, a_stall_e, a_stall_m, a_flush_d, a_flush_e, a_flush_w};
    assign b_vec = {b_stall_f, b_stall_d, b_stall_e, b_stall_m, b_flush_d, b_flush_e, b_flush_w};

    localparam logic [6:0] VecNone   = 7'b0000000;
    localparam logic [6:0] VecFreeze = 7'b1111001;
    localparam logic [6:0] VecBranch = 7'b0000110;
    localparam logic [6:0] VecLoad   = 7'b1100010;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl_param #(.MISS_PENALTY(5)) u_dut_p5 (
        .CLK(CLK), .CLR(CLR), .hit(hit),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .WriteRegM(WriteRegM), .WriteRegW(WriteRegW), .PCSrcE(PCSrcE),
        .StallF(a_stall_f), .StallD(a_stall_d), .StallE(a_stall_e), .StallM(a_stall_m),
        .FlushD(a_flush_d), .FlushE(a_flush_e), .FlushW(a_flush_w),
        .ForwardAE(a_fwd_a), .ForwardBE(a_fwd_b)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_stall(a_perf_stall), .perf_miss(a_perf_miss), .perf_flush(a_perf_flush)
`endif
    );

    hazard_ctrl_param #(.MISS_PENALTY(1)) u_dut_p1 (
        .CLK(CLK), .CLR(CLR), .hit(hit),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .WriteRegM(WriteRegM), .WriteRegW(WriteRegW), .PCSrcE(PCSrcE),
        .StallF(b_stall_f), .StallD(b_stall_d), .StallE(b_stall_e), .StallM(b_stall_m),
        .FlushD(b_flush_d), .FlushE(b_flush_e), .FlushW(b_flush_w),
        .ForwardAE(b_fwd_a), .ForwardBE(b_fwd_b)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_stall(b_perf_stall), .perf_miss(b_perf_miss), .perf_flush(b_perf_flush)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        hit       = 1'b1;
        RsD       = '0;
        RtD       = '0;
        RsE       = '0;
        RtE       = '0;
        WriteRegM = '0;
        WriteRegW = '0;
        MemtoRegE = 1'b0;
        MemtoRegM = 1'b0;
        MemWriteM = 1'b0;
        RegWriteM = 1'b0;
        RegWriteW = 1'b0;
        PCSrcE    = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with a miss and a forwarding match present: everything stays quiet.
        CLR = 1'b0;
        idle_inputs();
        MemtoRegM = 1'b1;
        hit       = 1'b0;
        RegWriteM = 1'b1;
        WriteRegM = 5'd7;
        RsE       = 5'd7;
        #2;
        check("rst_vec", a_vec, VecNone);
        check("rst_fwd_a", a_fwd_a, 2'b00);
        #10;
        CLR = 1'b1;
        idle_inputs();

        tick();
        check("idle_vec", a_vec, VecNone);

        // Forwarding priority and register-0 exclusion.
        RegWriteM = 1'b1; RegWriteW = 1'b1; WriteRegM = 5'd7; WriteRegW = 5'd7;
        RsE = 5'd7; RtE = 5'd7;
        #1;
        check("fwd_a_m_wins", a_fwd_a, 2'b10);
        check("fwd_b_m_wins", a_fwd_b, 2'b10);
        RsE = 5'd0;
        #1;
        check("fwd_a_r0", a_fwd_a, 2'b00);
        RsE = 5'd7; RegWriteM = 1'b0;
        #1;
        check("fwd_a_w_only", a_fwd_a, 2'b01);
        RegWriteM = 1'b1; WriteRegM = 5'd5;
        #1;
        check("fwd_a_m_other_reg", a_fwd_a, 2'b01);
        check("fwd_b_m_other_reg", a_fwd_b, 2'b01);
        RegWriteW = 1'b0;
        #1;
        check("fwd_a_none", a_fwd_a, 2'b00);

        // Load-use hazard on RsD, then RtD, then with RtE = 0.
        tick();
        idle_inputs();
        MemtoRegE = 1'b1; RtE = 5'd3; RsD = 5'd3;
        #1;
        check("lw_rs_vec", a_vec, VecLoad);
        RsD = 5'd0; RtD = 5'd3;
        #1;
        check("lw_rt_vec", a_vec, VecLoad);
        RtD = 5'd0; RtE = 5'd0;
        #1;
        check("lw_r0_vec", a_vec, VecNone);

        // The load has moved to M (hit): no second stall, operand comes from M.
        tick();
        idle_inputs();
        MemtoRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd3; RsE = 5'd3;
        #1;
        check("lw_next_vec", a_vec, VecNone);
        check("lw_next_fwd_a", a_fwd_a, 2'b10);

        // Taken branch beats load-use.
        tick();
        idle_inputs();
        MemtoRegE = 1'b1; RtE = 5'd3; RsD = 5'd3; PCSrcE = 1'b1;
        #1;
        check("br_over_lw_vec", a_vec, VecBranch);

        // Miss at cycle t; hit returns at t+1 (ignored by the 5-cycle instance),
        // branch appears at t+2 and must wait until t+5 on the 5-cycle instance.
        tick();
        idle_inputs();
        MemtoRegM = 1'b1; hit = 1'b0;
        #1;
        check("miss_t_p5", a_vec, VecFreeze);
        check("miss_t_p1", b_vec, VecFreeze);
        for (int i = 1; i <= 4; i++) begin
            tick();
            hit = 1'b1;
            if (i >= 2) PCSrcE = 1'b1;
            #1;
            check($sformatf("miss_t%0d_p5", i), a_vec, VecFreeze);
            check($sformatf("miss_t%0d_p1", i), b_vec, (i >= 2) ? VecBranch : VecNone);
        end
        tick();
        #1;
        check("miss_t5_p5_branch", a_vec, VecBranch);

        // Reset dropped two cycles into a miss.
        tick();
        idle_inputs();
        MemtoRegM = 1'b1; hit = 1'b0;
        tick();
        hit = 1'b1;
        tick();
        #1;
        check("rstmid_frozen", a_vec, VecFreeze);
        CLR = 1'b0;
        RegWriteM = 1'b1; WriteRegM = 5'd7; RsE = 5'd7;
        #1;
        check("rstmid_vec", a_vec, VecNone);
        check("rstmid_fwd_a", a_fwd_a, 2'b00);
`ifdef HAZ_PERF_CNT_EN
        check("rstmid_perf_stall", a_perf_stall, 32'd0);
        check("rstmid_perf_miss", a_perf_miss, 32'd0);
        check("rstmid_perf_flush", a_perf_flush, 32'd0);
`endif
        #2;
        CLR = 1'b1;
        #1;
        // Back in RUN with hit=1: a leftover MISS state would still freeze here.
        check("rstmid_release_vec", a_vec, VecNone);
        check("rstmid_release_fwd_a", a_fwd_a, 2'b10);
        tick();
        check("rstmid_after_vec", a_vec, VecNone);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
